// File: rtl/npu_cmd_queue_if.sv
// Register-write, NPU command and status signals of npu_cmd_queue.
// master: register slave / NPU side; slave: the command queue.
interface npu_cmd_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) ();
  logic              reg_wr_en;
  logic [1:0]        reg_wr_addr;
  logic [31:0]       reg_wr_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_src;
  logic [ADDR_W-1:0] cmd_dst;
  logic [LEN_W-1:0]  cmd_len;
  logic              npu_done;
  logic [31:0]       status_word;
  logic              irq;

  modport master (
    output reg_wr_en, reg_wr_addr, reg_wr_data, cmd_ready, npu_done,
    input  cmd_valid, cmd_src, cmd_dst, cmd_len, status_word, irq
  );

  modport slave (
    input  reg_wr_en, reg_wr_addr, reg_wr_data, cmd_ready, npu_done,
    output cmd_valid, cmd_src, cmd_dst, cmd_len, status_word, irq
  );
endinterface

// File: rtl/npu_cmd_queue.sv
// NPU command front end: SRC/DST/LEN shadows, DEPTH-entry command FIFO, one-job-at-a-time issue.
// Define NPU_CMDQ_IRQ_EN to build the done_pend sticky and the completion interrupt.
module npu_cmd_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input logic             ACLK,
  input logic             ARESET,
  npu_cmd_queue_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = 2 * ADDR_W + LEN_W;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [EntW-1:0]   mem_q [DEPTH];
  logic [EntW-1:0]   mem_d [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [ADDR_W-1:0] cmd_src_q, cmd_src_d, cmd_dst_q, cmd_dst_d;
  logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
  logic              ovf_q, ovf_d, zlen_q, zlen_d, spur_q, spur_d;
  logic [15:0]       done_cnt_q, done_cnt_d;

  logic ctrl_wr, go, clr, fifo_full, fifo_empty, pop, push, job_done, done_pend;

  assign ctrl_wr    = bus.reg_wr_en && (bus.reg_wr_addr == 2'd0);
  assign go         = ctrl_wr && bus.reg_wr_data[0];
  assign clr        = ctrl_wr && bus.reg_wr_data[1];
  assign fifo_full  = (count_q == CntW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  // The head stays in the FIFO while offered and leaves on the handshake.
  assign pop        = (state_q == StIssue) && bus.cmd_ready;
  assign push       = go && (len_q != '0) && (!fifo_full || pop);
  assign job_done   = (state_q == StWaitDone) && bus.npu_done;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cmd_src_d  = cmd_src_q;
    cmd_dst_d  = cmd_dst_q;
    cmd_len_d  = cmd_len_q;
    ovf_d      = ovf_q;
    zlen_d     = zlen_q;
    spur_d     = spur_q;
    done_cnt_d = done_cnt_q;

    if (bus.reg_wr_en) begin
      if (bus.reg_wr_addr == 2'd1) src_d = bus.reg_wr_data[ADDR_W-1:0];
      if (bus.reg_wr_addr == 2'd2) dst_d = bus.reg_wr_data[ADDR_W-1:0];
      if (bus.reg_wr_addr == 2'd3) len_d = bus.reg_wr_data[LEN_W-1:0];
    end

    // Clear first so a same-cycle set wins.
    if (clr) begin
      ovf_d  = 1'b0;
      zlen_d = 1'b0;
      spur_d = 1'b0;
    end
    if (go && (len_q == '0)) zlen_d = 1'b1;
    if (go && (len_q != '0) && fifo_full && !pop) ovf_d = 1'b1;
    if (bus.npu_done && (state_q != StWaitDone)) spur_d = 1'b1;

    if (push) begin
      mem_d[wr_ptr_q] = {src_q, dst_q, len_q};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CntW'(push) - CntW'(pop);

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          {cmd_src_d, cmd_dst_d, cmd_len_d} = mem_q[rd_ptr_q];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (bus.cmd_ready) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (job_done) begin
          state_d    = StIdle;
          done_cnt_d = done_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= StIdle;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cmd_src_q  <= '0;
      cmd_dst_q  <= '0;
      cmd_len_q  <= '0;
      ovf_q      <= 1'b0;
      zlen_q     <= 1'b0;
      spur_q     <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cmd_src_q  <= cmd_src_d;
      cmd_dst_q  <= cmd_dst_d;
      cmd_len_q  <= cmd_len_d;
      ovf_q      <= ovf_d;
      zlen_q     <= zlen_d;
      spur_q     <= spur_d;
      done_cnt_q <= done_cnt_d;
    end
  end

`ifdef NPU_CMDQ_IRQ_EN
  logic irq_en_q, irq_en_d, done_pend_q, done_pend_d, irq_q, irq_d;

  always_comb begin
    irq_en_d    = irq_en_q;
    done_pend_d = done_pend_q;
    if (ctrl_wr) irq_en_d = bus.reg_wr_data[2];
    if (clr) done_pend_d = 1'b0;
    if (job_done) done_pend_d = 1'b1;
    irq_d = irq_en_q && done_pend_q;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      irq_en_q    <= 1'b0;
      done_pend_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      irq_en_q    <= irq_en_d;
      done_pend_q <= done_pend_d;
      irq_q       <= irq_d;
    end
  end

  assign done_pend = done_pend_q;
  assign bus.irq   = irq_q;
`else
  assign done_pend = 1'b0;
  assign bus.irq   = 1'b0;
`endif

  assign bus.cmd_valid   = (state_q == StIssue);
  assign bus.cmd_src     = cmd_src_q;
  assign bus.cmd_dst     = cmd_dst_q;
  assign bus.cmd_len     = cmd_len_q;
  assign bus.status_word = {done_cnt_q, 8'(count_q), 1'b0, done_pend, spur_q, zlen_q, ovf_q,
                            fifo_empty, fifo_full, (state_q != StIdle)};
endmodule
